// File: rtl/ft2232h_rx_ctrl_if.sv
// Bus bundle between the FT2232H RX controller, the FT2232H pins and the command parser.
// master = controller side, slave = pins/consumer side.
interface ft2232h_rx_ctrl_if #(
    parameter int CW = 32
);
    logic [7:0]    data_i;
    logic          rxf_i;
    logic          oe_o;
    logic          rd_o;
    logic [7:0]    dout_o;
    logic          dvalid_o;
    logic          dready_i;
    logic [CW-1:0] rx_count_o;

    modport master (
        input  data_i, rxf_i, dready_i,
        output oe_o, rd_o, dout_o, dvalid_o, rx_count_o
    );

    modport slave (
        output data_i, rxf_i, dready_i,
        input  oe_o, rd_o, dout_o, dvalid_o, rx_count_o
    );
endinterface

// File: rtl/ft2232h_rx_ctrl.sv
// FT2232H sync-245 receive controller: OE#/RD# sequencing into a first-word-fall-through byte FIFO.
// Optional received-byte counter enabled by FT2232H_RX_BYTECOUNT_EN.
module ft2232h_rx_ctrl #(
    parameter int DEPTH = 8,
    parameter int CW    = 32
) (
    input  logic                 clkout_i,
    input  logic                 rst_n_i,
    ft2232h_rx_ctrl_if.master    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);

    typedef enum logic [1:0] {IDLE, OE, READ} state_t;

    state_t          state_q, state_d;
    logic            oe_q, oe_d;
    logic            rd_q, rd_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [NW-1:0]   count_q, count_d;
    logic [NW-1:0]   after_pop;
    logic [7:0]      dout_q, dout_d;
    logic            dvalid_q, dvalid_d;
    logic            push, pop;

    always_comb begin
        push      = (state_q == READ) && !bus.rxf_i;
        pop       = dvalid_q && bus.dready_i;
        after_pop = count_q - NW'(pop);
        count_d   = after_pop + NW'(push);
        wptr_d    = wptr_q + AW'(push);
        rptr_d    = rptr_q + AW'(pop);
        dvalid_d  = (count_d != '0);

        // Head register: next stored entry if one remains, else bypass the incoming byte.
        dout_d = dout_q;
        if (after_pop != '0)
            dout_d = mem_q[rptr_d];
        else if (push)
            dout_d = bus.data_i;

        state_d = state_q;
        case (state_q)
            IDLE:    if (!bus.rxf_i && count_d < DEPTH_N) state_d = OE;
            OE:      state_d = bus.rxf_i ? IDLE : READ;
            READ:    if (bus.rxf_i || count_d >= DEPTH_N) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        oe_d = (state_d == IDLE);
        rd_d = (state_d != READ);
    end

    always_ff @(posedge clkout_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            oe_q     <= 1'b1;
            rd_q     <= 1'b1;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            dout_q   <= 8'h00;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            oe_q     <= oe_d;
            rd_q     <= rd_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clkout_i) begin
        if (push)
            mem_q[wptr_q] <= bus.data_i;
    end

    assign bus.oe_o     = oe_q;
    assign bus.rd_o     = rd_q;
    assign bus.dout_o   = dout_q;
    assign bus.dvalid_o = dvalid_q;

`ifdef FT2232H_RX_BYTECOUNT_EN
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;

    always_comb rx_cnt_d = rx_cnt_q + CW'(push);

    always_ff @(posedge clkout_i or negedge rst_n_i) begin
        if (!rst_n_i) rx_cnt_q <= '0;
        else          rx_cnt_q <= rx_cnt_d;
    end

    assign bus.rx_count_o = rx_cnt_q;
`else
    assign bus.rx_count_o = '0;
`endif

endmodule

// File: tb/tb_ft2232h_rx_ctrl.sv
// Directed bench for ft2232h_rx_ctrl: single byte, burst, backpressure, RXF# toggling, mid-burst reset.
module tb_ft2232h_rx_ctrl;
`ifdef FT2232H_RX_BYTECOUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    ft2232h_rx_ctrl_if #(.CW(32)) bus ();

    ft2232h_rx_ctrl #(.DEPTH(8), .CW(32)) dut (
        .clkout_i (clk),
        .rst_n_i  (rst_n),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int n);
        chk(tag, bus.rx_count_o, CNT_EN ? 32'(n) : 32'd0);
    endtask

    // Drive RXF#/data for the next edge, clock it, then check the registered outputs.
    task automatic step(input string tag, input logic rxf, input logic [7:0] d,
                        input logic e_oe, input logic e_rd, input logic e_v,
                        input logic [7:0] e_dout);
        bus.rxf_i  = rxf;
        bus.data_i = d;
        tick();
        chk({tag, ".oe"}, 32'(bus.oe_o), 32'(e_oe));
        chk({tag, ".rd"}, 32'(bus.rd_o), 32'(e_rd));
        chk({tag, ".v"},  32'(bus.dvalid_o), 32'(e_v));
        if (e_v) chk({tag, ".dout"}, 32'(bus.dout_o), 32'(e_dout));
    endtask

    initial begin
        bus.rxf_i    = 1'b1;
        bus.data_i   = 8'h00;
        bus.dready_i = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst.oe",   32'(bus.oe_o), 32'd1);
        chk("rst.rd",   32'(bus.rd_o), 32'd1);
        chk("rst.v",    32'(bus.dvalid_o), 32'd0);
        chk("rst.dout", 32'(bus.dout_o), 32'h00);
        chk("rst.cnt",  bus.rx_count_o, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single byte A5
        step("sb_e0", 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00);
        step("sb_e1", 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
        step("sb_e2", 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5);
        step("sb_up", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
        chk_cnt("sb.cnt", 1);

        // 20-byte burst, one byte out per cycle
        step("bu_e0", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        step("bu_e1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++)
            step($sformatf("bu%0d", i), 1'b0, 8'(i), 1'b0, 1'b0, 1'b1, 8'(i));
        step("bu_up", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
        chk_cnt("bu.cnt", 21);   // 1 + 20 since reset

        // Backpressure: 8 captures fill the FIFO, RD# rises on the 8th
        bus.dready_i = 1'b0;
        step("bp_e0", 1'b0, 8'h30, 1'b0, 1'b1, 1'b0, 8'h00);
        step("bp_e1", 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 7; k++)
            step($sformatf("bp%0d", k), 1'b0, 8'(8'h30 + k), 1'b0, 1'b0, 1'b1, 8'h30);
        step("bp_full", 1'b0, 8'h37, 1'b1, 1'b1, 1'b1, 8'h30);
        step("bp_hold", 1'b0, 8'h38, 1'b1, 1'b1, 1'b1, 8'h30);
        chk_cnt("bp.cnt8", 29);
        bus.dready_i = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            step($sformatf("dr%0d", k),
                 (k <= 5) ? 1'b0 : 1'b1,
                 (k >= 2) ? 8'(8'h36 + k) : 8'h38,
                 (k <= 5) ? 1'b0 : 1'b1,
                 (k >= 1 && k <= 5) ? 1'b0 : 1'b1,
                 1'b1, 8'(8'h31 + k));
        end
        step("dr_empty", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
        chk_cnt("bp.cnt", 33);

        // RXF# toggling: capture only when sampled low in READ
        step("tg0", 1'b0, 8'h50, 1'b0, 1'b1, 1'b0, 8'h00);
        step("tg1", 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0, 8'h00);
        step("tg2", 1'b0, 8'h51, 1'b0, 1'b0, 1'b1, 8'h51);
        step("tg3", 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 8'h00);
        step("tg4", 1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 8'h00);
        step("tg5", 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 8'h00);
        step("tg6", 1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 8'h00);
        step("tg7", 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0, 8'h00);
        step("tg8", 1'b0, 8'h52, 1'b0, 1'b0, 1'b1, 8'h52);
        step("tg9", 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 8'h00);
        chk_cnt("tg.cnt", 35);

        // Reset mid-burst after 3 bytes
        bus.dready_i = 1'b0;
        step("mr_e0", 1'b0, 8'h60, 1'b0, 1'b1, 1'b0, 8'h00);
        step("mr_e1", 1'b0, 8'h60, 1'b0, 1'b0, 1'b0, 8'h00);
        step("mr0",   1'b0, 8'h60, 1'b0, 1'b0, 1'b1, 8'h60);
        step("mr1",   1'b0, 8'h61, 1'b0, 1'b0, 1'b1, 8'h60);
        step("mr2",   1'b0, 8'h62, 1'b0, 1'b0, 1'b1, 8'h60);
        #2 rst_n = 1'b0;
        #1;
        chk("mr.oe",   32'(bus.oe_o), 32'd1);
        chk("mr.rd",   32'(bus.rd_o), 32'd1);
        chk("mr.v",    32'(bus.dvalid_o), 32'd0);
        chk("mr.dout", 32'(bus.dout_o), 32'h00);
        chk("mr.cnt",  bus.rx_count_o, 32'd0);
        tick();
        chk("mr.hold_oe", 32'(bus.oe_o), 32'd1);
        rst_n = 1'b1;
        bus.dready_i = 1'b1;
        step("pr_e0", 1'b0, 8'h70, 1'b0, 1'b1, 1'b0, 8'h00);
        step("pr_e1", 1'b0, 8'h70, 1'b0, 1'b0, 1'b0, 8'h00);
        step("pr_e2", 1'b0, 8'h70, 1'b0, 1'b0, 1'b1, 8'h70);
        step("pr_up", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
        chk_cnt("pr.cnt", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ft2232h_rx_ctrl.md
# ft2232h_rx_ctrl

FPGA-side receive controller for the FT2232H synchronous 245 FIFO interface, carrying bytes from the PC into the FPGA. It drives the chip's active-low output-enable and read strobes and captures bytes on `clkout_i` while the chip reports data available. Captured bytes go into an internal FIFO and leave on a first-word-fall-through valid/ready port to the command parser. It complements the PC-bound write path on the same `clkout_i` domain.

## Interface
- `DEPTH`, 8: internal FIFO depth in bytes; power of two, at least 4.
- `CW`, 32: width of the received-byte counter.
- `clkout_i`  in  1: 60 MHz FT2232H CLKOUT; the only clock.
- `rst_n_i`  in  1: reset, asynchronous assert, active-low.
- `data_i`  in  8: FT2232H ADBUS data from the chip.
- `rxf_i`  in  1: FT2232H RXF#, active low; low means a byte is available.
- `oe_o`  out  1: FT2232H OE#, active low; high means the chip does not drive the bus.
- `rd_o`  out  1: FT2232H RD#, active low.
- `dout_o`  out  8: head-of-FIFO byte.
- `dvalid_o`  out  1: `dout_o` holds a valid byte.
- `dready_i`  in  1: consumer accepts the byte; a pop occurs when `dvalid_o & dready_i`.
- `rx_count_o`  out  CW: running count of captured bytes (see Configuration).

## Operation
- Reset values: `oe_o=1`, `rd_o=1`, `dvalid_o=0`, `dout_o=8'h00`, `rx_count_o=0`. FIFO is empty and the FSM is in IDLE.
- All outputs come from registers; there is no combinational path from an input to an output.
- `next_count` = current count + capture this edge − pop this edge.
- States and transitions:
  - IDLE (`oe_o=1`, `rd_o=1`): go to OE when `rxf_i==0` and `next_count < DEPTH`.
  - OE (`oe_o=0`, `rd_o=1`): lasts exactly 1 cycle (bus turnaround), then READ. If `rxf_i` is high at this edge, go to IDLE instead.
  - READ (`oe_o=0`, `rd_o=0`): on each edge with `rxf_i==0`, push `data_i`. Stay in READ while `rxf_i==0` and `next_count < DEPTH`. Otherwise go to IDLE, with `oe_o` and `rd_o` going high at that edge.
- Bytes are captured only in READ with `rxf_i` sampled low. `data_i` is ignored in every other case.
- Overflow protection: the FIFO never overflows. A capture is never attempted when the FIFO is full, because READ is left at the edge where `next_count` reaches `DEPTH`.
- FIFO behaviour:
  - First-word-fall-through: `dout_o`/`dvalid_o` update at the edge after a push into an empty FIFO.
  - A pop and a push on the same edge leave the count unchanged.
  - Read and write pointers wrap modulo `DEPTH`.
- `dout_o` holds its value while `dvalid_o & ~dready_i`.
- Reset asserted mid-burst forces `oe_o`/`rd_o` high immediately (asynchronously) and empties the FIFO. Bytes in flight are lost.

## Timing
- Latency, with `rxf_i` falling before edge E0 and the FIFO empty:
  - E0: enter OE; `oe_o` goes low.
  - E1: enter READ; `rd_o` goes low.
  - E2: first byte captured.
  - After E2: `dvalid_o=1`.
- Sustained throughput is 1 byte per `clkout_i` cycle while `rxf_i` is low and the consumer keeps `dready_i=1`.
- When `rxf_i` rises, `rd_o` rises at the first edge that samples it high. No byte is captured at that edge.
- Re-entry after a stall: `rd_o` is always preceded by at least 1 cycle of `oe_o=0` with `rd_o=1`.

## Configuration
- `FT2232H_RX_BYTECOUNT_EN` defined:
  - `rx_count_o` increments by 1 on every capture edge and wraps at 2^CW.
  - It is cleared only by reset.
- Not defined: `rx_count_o` is tied to 0 and the counter logic is not synthesized.

## Test plan
- Single byte: `rxf_i` low for 1 byte of `8'hA5`, `dready_i=1` → `oe_o` low at E0, `rd_o` low at E1, `dout_o=8'hA5` with `dvalid_o=1` after E2, then `oe_o`/`rd_o` high after `rxf_i` rises.
- Burst of 20 bytes `0x00..0x13`, `dready_i=1` → 20 bytes out in order, no gaps after the first, `rx_count_o=20` (macro defined).
- Backpressure, `DEPTH=8`, `dready_i=0`, 12 bytes offered → `rd_o` rises at the edge of the 8th capture, exactly 8 bytes held. With `dready_i=1` the 8 bytes drain, `oe_o` precedes `rd_o` by 1 cycle, and the remaining 4 bytes are received in order.
- `rxf_i` toggling every cycle during READ → a byte is captured only on edges where `rxf_i` is low, and the FSM returns to IDLE/OE each time.
- Reset asserted mid-burst after 3 bytes → `oe_o=1`, `rd_o=1`, `dvalid_o=0`, `rx_count_o=0` immediately; the next burst behaves as after power-up.
- Macro undefined, 5-byte burst → data path identical, `rx_count_o` stays 0.
